clock_register_alarm: RTL

CLOCK_REGISTER_ALARM -- requirements
Module: clock_register_alarm

---
 rtl/clock_pkg.sv | 30 +++
 rtl/wrap_counter.sv | 28 ++
 rtl/clock_register_alarm.sv | 129 ++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared constants, set-mode encoding and 12-hour display mapping for the
// clock/alarm block.
package clock_pkg;

    localparam int HOURS_MAX = 23;
    localparam int HOUR_W    = 5;
    localparam int MIN_W     = 6;
    localparam int SEC_W     = 6;

    localparam logic [HOUR_W-1:0] NOON_HOUR     = 5'd12;
    localparam logic [HOUR_W-1:0] DISP_MIDNIGHT = 5'd12;

    // Encoded as {set_minutes, set_hours}
    typedef enum logic [1:0] {
        SET_NONE    = 2'b00,
        SET_HOURS   = 2'b01,
        SET_MINUTES = 2'b10,
        SET_BOTH    = 2'b11
    } set_sel_t;

    function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] hours);
        if (hours == '0)
            return DISP_MIDNIGHT;
        else if (hours > NOON_HOUR)
            return hours - NOON_HOUR;
        else
            return hours;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with increment, synchronous clear and a carry that
// flags the increment which wraps MAX back to zero.
module wrap_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign carry = inc && !clr && (value == MAX_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (inc)
            value <= carry ? '0 : value + 1'b1;
    end

endmodule

// File: rtl/clock_register_alarm.sv
// 24-hour time-of-day register with set controls, optional alarm compare,
// midnight pulse and a 12-hour display view.
module clock_register_alarm
    import clock_pkg::*;
#(
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int ALARM_EN = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_1hz_stb,
    input  logic              i_set_stb,
    input  logic              i_set_hours,
    input  logic              i_set_minutes,
    input  logic              i_alarm_sel,
    input  logic              i_alarm_en,
    input  logic              i_mode_12h,
    output logic [HOUR_W-1:0] o_hours,
    output logic [MIN_W-1:0]  o_minutes,
    output logic [SEC_W-1:0]  o_seconds,
    output logic [HOUR_W-1:0] o_disp_hours,
    output logic [0:0]        o_pm,
    output logic [HOUR_W-1:0] o_alarm_hours,
    output logic [MIN_W-1:0]  o_alarm_minutes,
    output logic              o_alarm_stb,
    output logic              o_day_stb
);

    set_sel_t          set_sel;
    logic              time_set;
    logic              run_mode;
    logic              sec_inc, sec_clr, sec_carry;
    logic              min_inc, min_carry;
    logic              hr_inc, hr_carry;
    logic [SEC_W-1:0]  seconds_q;
    logic [MIN_W-1:0]  minutes_q;
    logic [HOUR_W-1:0] hours_q;
    logic [MIN_W-1:0]  minutes_next;
    logic [HOUR_W-1:0] hours_next;
    logic              day_stb_reg;

    assign set_sel  = set_sel_t'({i_set_minutes, i_set_hours});
    assign time_set = !i_alarm_sel && (set_sel != SET_NONE);
    assign run_mode = !time_set;

    // In time-set the seconds tick is ignored and minute edits never carry.
    assign sec_inc = run_mode && i_1hz_stb;
    assign sec_clr = time_set && (set_sel == SET_BOTH) && i_set_stb;
    assign min_inc = run_mode ? sec_carry
                              : ((set_sel == SET_MINUTES) && i_set_stb);
    assign hr_inc  = run_mode ? min_carry
                              : ((set_sel == SET_HOURS) && i_set_stb);

    wrap_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_seconds (
        .clk(i_clk), .rst(i_reset), .inc(sec_inc), .clr(sec_clr),
        .value(seconds_q), .carry(sec_carry)
    );

    wrap_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_minutes (
        .clk(i_clk), .rst(i_reset), .inc(min_inc), .clr(1'b0),
        .value(minutes_q), .carry(min_carry)
    );

    wrap_counter #(.WIDTH(HOUR_W), .MAX(HOURS_MAX)) u_hours (
        .clk(i_clk), .rst(i_reset), .inc(hr_inc), .clr(1'b0),
        .value(hours_q), .carry(hr_carry)
    );

    // Time after a seconds wrap; only meaningful when sec_carry is set.
    assign minutes_next = min_carry ? '0 : minutes_q + 1'b1;
    assign hours_next   = hr_carry  ? '0 : (min_carry ? hours_q + 1'b1 : hours_q);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            day_stb_reg <= 1'b0;
        else
            day_stb_reg <= run_mode && hr_carry;
    end

    generate
        if (ALARM_EN != 0) begin : g_alarm
            logic              alarm_stb_reg;
            logic              ah_inc, am_inc;
            logic              ah_carry_unused, am_carry_unused;
            logic [HOUR_W-1:0] alarm_hours_q;
            logic [MIN_W-1:0]  alarm_minutes_q;

            assign ah_inc = i_alarm_sel && i_set_stb && (set_sel == SET_HOURS);
            assign am_inc = i_alarm_sel && i_set_stb && (set_sel == SET_MINUTES);

            wrap_counter #(.WIDTH(HOUR_W), .MAX(HOURS_MAX)) u_alarm_hours (
                .clk(i_clk), .rst(i_reset), .inc(ah_inc), .clr(1'b0),
                .value(alarm_hours_q), .carry(ah_carry_unused)
            );

            wrap_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_alarm_minutes (
                .clk(i_clk), .rst(i_reset), .inc(am_inc), .clr(1'b0),
                .value(alarm_minutes_q), .carry(am_carry_unused)
            );

            // Only a running tick that lands on hh:mm:00 can fire the alarm.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset)
                    alarm_stb_reg <= 1'b0;
                else
                    alarm_stb_reg <= i_alarm_en && sec_carry
                                     && (hours_next == alarm_hours_q)
                                     && (minutes_next == alarm_minutes_q);
            end

            assign o_alarm_hours   = alarm_hours_q;
            assign o_alarm_minutes = alarm_minutes_q;
            assign o_alarm_stb     = alarm_stb_reg;
        end else begin : g_no_alarm
            assign o_alarm_hours   = '0;
            assign o_alarm_minutes = '0;
            assign o_alarm_stb     = 1'b0;
        end
    endgenerate

    assign o_hours      = hours_q;
    assign o_minutes    = minutes_q;
    assign o_seconds    = seconds_q;
    assign o_day_stb    = day_stb_reg;
    assign o_pm         = (hours_q >= NOON_HOUR);
    assign o_disp_hours = i_mode_12h ? to_12h(hours_q) : hours_q;

endmodule
